// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle RV64M integer divider for DIV/DIVU/REM/REMU and
//               their W forms. It uses radix-2 restoring division and
//               retires one quotient bit per cycle. Both sides use
//               valid/ready handshakes.
// Ports       : clk        - clock
//               reset      - synchronous active-high reset
//               flush      - abort the current operation and return to idle
//               in_valid   - request present   / in_ready  - unit idle
//               a, b       - dividend, divisor
//               op         - 0=DIV 1=DIVU 2=REM 3=REMU
//               is_word    - W form: 32-bit operands, sign-extended result
//               out_valid  - result valid      / out_ready - consumer takes it
//               result     - quotient or remainder
// Config      : DIV_FAST_SPECIAL_EN - when defined, divide-by-zero and
//               signed overflow go straight to DONE one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    input  logic            is_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int c_half  = XLEN / 2;
    localparam int c_cnt_w = $clog2(XLEN) + 1;

    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_word = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_dvd;      // dividend shifts out at the top, quotient bits shift in at the bottom
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;
    logic               r_word;
    logic               r_div0;
    logic               r_ovf;
    logic [XLEN-1:0]    r_a_ext;
    logic [XLEN-1:0]    r_result;

    // ------------------------------------------------------------------
    // Operand preparation (evaluated on the accept cycle)
    // ------------------------------------------------------------------
    logic            w_signed;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN-1:0] w_min;
    logic            w_div0;
    logic            w_ovf;
    logic            w_accept;

    assign w_signed = ~op[0];
    assign w_a_ext  = is_word ? {{c_half{w_signed & a[c_half-1]}}, a[c_half-1:0]} : a;
    assign w_b_ext  = is_word ? {{c_half{w_signed & b[c_half-1]}}, b[c_half-1:0]} : b;
    assign w_sa     = w_signed & w_a_ext[XLEN-1];
    assign w_sb     = w_signed & w_b_ext[XLEN-1];
    assign w_a_abs  = w_sa ? -w_a_ext : w_a_ext;
    assign w_b_abs  = w_sb ? -w_b_ext : w_b_ext;

    // Most negative value of the operand width, in its extended 64-bit form
    assign w_min    = is_word ? {{(c_half+1){1'b1}}, {(c_half-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0   = (w_b_ext == '0);
    assign w_ovf    = w_signed & (w_a_ext == w_min) & (&w_b_ext);
    assign w_accept = in_valid & (r_state == c_st_idle) & ~flush;

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // The shifted partial remainder needs one extra bit: with an unsigned
    // divisor near 2^XLEN it can exceed XLEN bits before the subtract.
    logic [XLEN:0]   w_rem_sh;
    logic            w_qbit;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_dvd_next;

    assign w_rem_sh   = {r_rem, r_dvd[XLEN-1]};
    assign w_qbit     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff     = w_rem_sh[XLEN-1:0] - r_dvs;
    assign w_rem_next = w_qbit ? w_diff : w_rem_sh[XLEN-1:0];
    assign w_dvd_next = {r_dvd[XLEN-2:0], w_qbit};

    // Sign fix-up, special-case override and W-form sign extension
    function automatic logic [XLEN-1:0] f_finish(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] rem,
        input logic            neg_q,
        input logic            neg_r,
        input logic            is_rem,
        input logic            word,
        input logic            div0,
        input logic            ovf,
        input logic [XLEN-1:0] a_ext
    );
        logic [XLEN-1:0] w_q;
        logic [XLEN-1:0] w_r;
        logic [XLEN-1:0] w_res;
        w_q   = word ? {{c_half{1'b0}}, q[c_half-1:0]} : q;
        w_q   = neg_q ? -w_q : w_q;
        w_r   = neg_r ? -rem : rem;
        w_res = is_rem ? w_r : w_q;
        if (div0) begin
            w_res = is_rem ? a_ext : '1;
        end else if (ovf) begin
            w_res = is_rem ? '0 : a_ext;
        end
        if (word) begin
            w_res = {{c_half{w_res[c_half-1]}}, w_res[c_half-1:0]};
        end
        return w_res;
    endfunction

`ifdef DIV_FAST_SPECIAL_EN
    logic [XLEN-1:0] w_fast_result;
    assign w_fast_result = f_finish('0, '0, 1'b0, 1'b0, op[1], is_word,
                                    w_div0, w_ovf, w_a_ext);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_st_idle: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef DIV_FAST_SPECIAL_EN
                    w_state_next = (w_div0 | w_ovf) ? c_st_done : c_st_busy;
`else
                    w_state_next = c_st_busy;
`endif
                end
            end
            c_st_busy: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
        if (flush) begin
            w_state_next = c_st_idle;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_ext  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= is_word ? c_cnt_word : c_cnt_full;
            // W forms left-justify the 32-bit magnitude so the dividend MSB is
            // always r_dvd[XLEN-1]; the quotient ends up in the low half.
            r_dvd    <= is_word ? {w_a_abs[c_half-1:0], {c_half{1'b0}}} : w_a_abs;
            r_rem    <= '0;
            r_dvs    <= w_b_abs;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_is_rem <= op[1];
            r_word   <= is_word;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_a_ext  <= w_a_ext;
`ifdef DIV_FAST_SPECIAL_EN
            if (w_div0 | w_ovf) begin
                r_result <= w_fast_result;
            end
`endif
        end else if ((r_state == c_st_busy) && !flush) begin
            r_cnt <= r_cnt - c_cnt_last;
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
            // The final step's outputs feed the result register directly so
            // DONE follows the last iteration without a separate fix-up cycle.
            if (r_cnt == c_cnt_last) begin
                r_result <= f_finish(w_dvd_next, w_rem_next, r_neg_q, r_neg_r,
                                     r_is_rem, r_word, r_div0, r_ovf, r_a_ext);
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. Directed vectors carry
//               hand-computed results; a reference model built on native
//               integer division checks every cycle where out_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        is_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        pending = 1'b0;
    logic [63:0] exp_res = '0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .is_word   (is_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference model: RISC-V M-extension semantics via native arithmetic
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] o, input logic w);
        logic [31:0] x32, y32, q32, r32;
        int          sx32, sy32;
        longint      sx, sy;
        logic [63:0] q, r;
        if (w) begin
            x32 = x[31:0];
            y32 = y[31:0];
            sx32 = x32;
            sy32 = y32;
            if (y32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = x32;
            end else if (o[0]) begin
                q32 = x32 / y32;
                r32 = x32 % y32;
            end else if (x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin
                q32 = x32;
                r32 = 32'd0;
            end else begin
                q32 = sx32 / sy32;
                r32 = sx32 % sy32;
            end
            return o[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        sx = x;
        sy = y;
        if (y == 64'd0) begin
            q = '1;
            r = x;
        end else if (o[0]) begin
            q = x / y;
            r = x % y;
        end else if (x == 64'h8000_0000_0000_0000 && y == '1) begin
            q = x;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return o[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [63:0] x, input logic [63:0] y,
                                      input logic [1:0] o, input logic w);
        if (w)
            return (y[31:0] == 32'd0) ||
                   (!o[0] && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
        return (y == 64'd0) || (!o[0] && x == 64'h8000_0000_0000_0000 && y == '1);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Every cycle with out_valid high is checked against the model
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_cmp++;
            if (!pending) begin
                n_err++;
                $display("FAIL spurious_out_valid: got out_valid=1, want 0");
            end else if (result !== exp_res || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL model_cycle: got result=%h in_ready=%b, want result=%h in_ready=0",
                         result, in_ready, exp_res);
            end
        end
    end

    task automatic run_op(input string name, input logic [63:0] x, input logic [63:0] y,
                          input logic [1:0] o, input logic w, input logic [63:0] want,
                          input int hold);
        int lat;
        int exp_lat;
        int n;
        exp_lat = w ? 33 : 65;
`ifdef DIV_FAST_SPECIAL_EN
        if (is_special(x, y, o, w)) exp_lat = 1;
`endif
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        a = x; b = y; op = o; is_word = w; in_valid = 1'b1;
        exp_res = model(x, y, o, w);
        @(posedge clk); #1;
        pending = 1'b1;
        // Keep requesting with different operands: must be ignored while busy
        a = ~x; b = ~y; op = ~o; is_word = ~w;
        lat = 1;
        if (exp_lat > 1)
            check({name, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check(name, result, want);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({name, "_valid_held"}, {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        pending = 1'b0;
        check({name, "_in_ready_after"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    typedef struct {
        string       name;
        logic [63:0] x;
        logic [63:0] y;
        logic [1:0]  o;
        logic        w;
        logic [63:0] want;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; is_word = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {result[61:0], in_ready, out_valid}, 64'd2);
        check("reset_result", result, 64'd0);
        reset = 1'b0;

        vecs.push_back('{"divu_100_7",  64'd100, 64'd7, 2'd1, 1'b0, 64'd14, 10});
        vecs.push_back('{"remu_100_7",  64'd100, 64'd7, 2'd3, 1'b0, 64'd2, 0});
        vecs.push_back('{"div_m7_2",    -64'sd7, 64'd2, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1});
        vecs.push_back('{"rem_m7_2",    -64'sd7, 64'd2, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{"rem_7_m2",    64'd7, -64'sd2, 2'd2, 1'b0, 64'd1, 0});
        vecs.push_back('{"divw_ovf",    64'h0000_0001_8000_0000, '1, 2'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 2});
        vecs.push_back('{"remw_ovf",    64'h0000_0001_8000_0000, '1, 2'd2, 1'b1, 64'd0, 0});
        vecs.push_back('{"divu_div0",   64'd5, 64'd0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3});
        vecs.push_back('{"remu_div0",   64'd5, 64'd0, 2'd3, 1'b0, 64'd5, 0});
        vecs.push_back('{"div_ovf",     64'h8000_0000_0000_0000, '1, 2'd0, 1'b0, 64'h8000_0000_0000_0000, 0});
        vecs.push_back('{"rem_ovf",     64'h8000_0000_0000_0000, '1, 2'd2, 1'b0, 64'd0, 0});
        vecs.push_back('{"divu_big",    '1, 64'h1_0000_0000, 2'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 0});
        vecs.push_back('{"remu_big",    '1, 64'h1_0000_0000, 2'd3, 1'b0, 64'h0000_0000_FFFF_FFFF, 0});
        vecs.push_back('{"divw_m20_3",  64'h1234_5678_FFFF_FFEC, 64'd3, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 0});
        vecs.push_back('{"remw_m20_3",  64'h1234_5678_FFFF_FFEC, 64'd3, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0});
        vecs.push_back('{"divuw_sext",  64'hFFFF_0000_8000_0000, 64'd1, 2'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0});
        vecs.push_back('{"remuw_f",     64'h0000_0000_FFFF_FFFF, 64'h10, 2'd3, 1'b1, 64'd15, 0});
        vecs.push_back('{"remw_div0",   64'h0000_0000_8000_0005, 64'hABCD_0000_0000_0000, 2'd2, 1'b1, 64'hFFFF_FFFF_8000_0005, 0});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].o, vecs[i].w, vecs[i].want, vecs[i].hold);

        // Flush twenty cycles into an operation, with a request in the flush cycle
        a = 64'd1000; b = 64'd7; op = 2'd1; is_word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1; a = 64'd5; b = 64'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", {62'd0, in_ready, out_valid}, 64'd2);
        repeat (70) begin
            @(posedge clk); #1;
        end
        check("flush_quiet", {62'd0, in_ready, out_valid}, 64'd2);
        run_op("divu_9_3", 64'd9, 64'd3, 2'd1, 1'b0, 64'd3, 0);

        // Reset in the middle of an operation clears everything
        a = 64'd77; b = 64'd5; op = 2'd1; is_word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_reset", {result[61:0], in_ready, out_valid}, 64'd2);
        run_op("divu_77_5", 64'd77, 64'd5, 2'd1, 1'b0, 64'd15, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
